axis_frame_framer: RTL and testbench

- Downstream neighbour of the AXIS/BRAM engine's M_AXIS read port.
- Accepts a raw beat stream and cuts it into frames of a programmed beat length.
- Frame count is also programmed; the block generates m_axis_tlast on the final beat of each frame.
- Registered 2-entry skid output decouples backpressure; completion is reported to control logic.

---
 rtl/axis_framer_pkg.sv | 10 +
 rtl/axis_skid_buffer.sv | 55 +++++
 rtl/axis_frame_framer.sv | 129 ++++++++++++
 tb/tb_axis_frame_framer.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_framer_pkg.sv
// rtl/axis_framer_pkg.sv - state encodings shared by the frame framer
package axis_framer_pkg;

  localparam int FRAMER_STATE_W = 2;

  localparam logic [FRAMER_STATE_W-1:0] E_FRAMER_IDLE  = 2'd0;
  localparam logic [FRAMER_STATE_W-1:0] E_FRAMER_RUN   = 2'd1;
  localparam logic [FRAMER_STATE_W-1:0] E_FRAMER_DRAIN = 2'd2;

endpackage

// File: rtl/axis_skid_buffer.sv
// rtl/axis_skid_buffer.sv - two-entry registered skid buffer
module axis_skid_buffer #(
  parameter int W = 73
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         empty
);

  // head drives the outputs directly; tail only fills while head is stalled
  logic         head_valid;
  logic [W-1:0] head_data;
  logic         tail_valid;
  logic [W-1:0] tail_data;
  logic         push;
  logic         pop;

  assign in_ready  = !tail_valid;
  assign out_valid = head_valid;
  assign out_data  = head_data;
  assign empty     = !head_valid;
  assign push      = in_valid && in_ready;
  assign pop       = head_valid && out_ready;

  // head reloads only when it is empty or being consumed, keeping data stable while stalled
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_valid <= 1'b0;
      head_data  <= '0;
      tail_valid <= 1'b0;
      tail_data  <= '0;
    end else if (pop || !head_valid) begin
      if (tail_valid) begin
        head_valid <= 1'b1;
        head_data  <= tail_data;
        tail_valid <= 1'b0;
      end else begin
        head_valid <= push;
        if (push) begin
          head_data <= in_data;
        end
      end
    end else if (push) begin
      tail_valid <= 1'b1;
      tail_data  <= in_data;
    end
  end

endmodule

// File: rtl/axis_frame_framer.sv
// rtl/axis_frame_framer.sv - cuts a raw beat stream into counted frames
module axis_frame_framer #(
  parameter int C_FRAMER_DATA_WIDTH = 64,
  parameter int C_FRAMER_LEN_WIDTH  = 12
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             ctrl_start,
  input  logic [C_FRAMER_LEN_WIDTH-1:0]    ctrl_frame_length,
  input  logic [C_FRAMER_LEN_WIDTH-1:0]    ctrl_frame_count,
  output logic                             ctrl_busy,
  output logic                             ctrl_done,
  output logic [C_FRAMER_LEN_WIDTH-1:0]    stat_frames_sent,
  input  logic                             s_axis_tvalid,
  output logic                             s_axis_tready,
  input  logic [C_FRAMER_DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [C_FRAMER_DATA_WIDTH/8-1:0] s_axis_tstrb,
  output logic                             m_axis_tvalid,
  input  logic                             m_axis_tready,
  output logic [C_FRAMER_DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [C_FRAMER_DATA_WIDTH/8-1:0] m_axis_tstrb,
  output logic                             m_axis_tlast
);

  import axis_framer_pkg::*;

  localparam int LW = C_FRAMER_LEN_WIDTH;
  localparam int SW = C_FRAMER_DATA_WIDTH / 8;
  localparam int PW = C_FRAMER_DATA_WIDTH + SW + 1;
  localparam logic [LW-1:0] LEN_ONE = {{(LW-1){1'b0}}, 1'b1};

  logic [FRAMER_STATE_W-1:0] state;
  logic [LW-1:0]             len_q;
  logic [LW-1:0]             frames_q;
  logic [LW-1:0]             beat_cnt;
  logic [LW-1:0]             frame_cnt;
  logic                      skid_in_ready;
  logic                      skid_empty;
  logic [PW-1:0]             skid_out;
  logic                      accept;
  logic                      tag_last;
  logic                      last_frame;
  logic                      zero_run;

  assign ctrl_busy     = (state != E_FRAMER_IDLE);
  assign s_axis_tready = (state == E_FRAMER_RUN) && skid_in_ready;
  assign accept        = s_axis_tvalid && s_axis_tready;
  // len_q and frames_q are nonzero whenever RUN is active, so the decrements cannot wrap
  assign tag_last      = (beat_cnt == len_q - LEN_ONE);
  assign last_frame    = (frame_cnt == frames_q - LEN_ONE);
  assign zero_run      = (ctrl_frame_length == '0) || (ctrl_frame_count == '0);

  axis_skid_buffer #(
    .W(PW)
  ) u_skid (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (accept),
    .in_ready (skid_in_ready),
    .in_data  ({tag_last, s_axis_tstrb, s_axis_tdata}),
    .out_valid(m_axis_tvalid),
    .out_ready(m_axis_tready),
    .out_data (skid_out),
    .empty    (skid_empty)
  );

  assign {m_axis_tlast, m_axis_tstrb, m_axis_tdata} = skid_out;

  // run control: latch the job, count beats and frames, finish once the skid has drained
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= E_FRAMER_IDLE;
      len_q     <= '0;
      frames_q  <= '0;
      beat_cnt  <= '0;
      frame_cnt <= '0;
      ctrl_done <= 1'b0;
    end else begin
      ctrl_done <= 1'b0;
      case (state)
        E_FRAMER_IDLE: begin
          if (ctrl_start) begin
            len_q     <= ctrl_frame_length;
            frames_q  <= ctrl_frame_count;
            beat_cnt  <= '0;
            frame_cnt <= '0;
            if (zero_run) begin
              ctrl_done <= 1'b1;
            end else begin
              state <= E_FRAMER_RUN;
            end
          end
        end
        E_FRAMER_RUN: begin
          if (accept) begin
            if (tag_last) begin
              beat_cnt  <= '0;
              frame_cnt <= frame_cnt + LEN_ONE;
              if (last_frame) begin
                state <= E_FRAMER_DRAIN;
              end
            end else begin
              beat_cnt <= beat_cnt + LEN_ONE;
            end
          end
        end
        E_FRAMER_DRAIN: begin
          if (skid_empty) begin
            ctrl_done <= 1'b1;
            state     <= E_FRAMER_IDLE;
          end
        end
        default: state <= E_FRAMER_IDLE;
      endcase
    end
  end

  // frames counted on the output side, cleared only when a new run is launched
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_frames_sent <= '0;
    end else if (state == E_FRAMER_IDLE && ctrl_start) begin
      stat_frames_sent <= '0;
    end else if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
      stat_frames_sent <= stat_frames_sent + LEN_ONE;
    end
  end

endmodule

// File: tb/tb_axis_frame_framer.sv
// tb/tb_axis_frame_framer.sv - randomized self-checking bench for axis_frame_framer
module tb_axis_frame_framer;

  localparam int DW = 64;
  localparam int LW = 12;
  localparam int SW = DW / 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          ctrl_start = 1'b0;
  logic [LW-1:0] ctrl_frame_length = '0;
  logic [LW-1:0] ctrl_frame_count = '0;
  logic          ctrl_busy;
  logic          ctrl_done;
  logic [LW-1:0] stat_frames_sent;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic [DW-1:0] s_axis_tdata = '0;
  logic [SW-1:0] s_axis_tstrb = '0;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b0;
  logic [DW-1:0] m_axis_tdata;
  logic [SW-1:0] m_axis_tstrb;
  logic          m_axis_tlast;

  always #5 clk = ~clk;

  axis_frame_framer #(
    .C_FRAMER_DATA_WIDTH(DW),
    .C_FRAMER_LEN_WIDTH (LW)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .ctrl_start       (ctrl_start),
    .ctrl_frame_length(ctrl_frame_length),
    .ctrl_frame_count (ctrl_frame_count),
    .ctrl_busy        (ctrl_busy),
    .ctrl_done        (ctrl_done),
    .stat_frames_sent (stat_frames_sent),
    .s_axis_tvalid    (s_axis_tvalid),
    .s_axis_tready    (s_axis_tready),
    .s_axis_tdata     (s_axis_tdata),
    .s_axis_tstrb     (s_axis_tstrb),
    .m_axis_tvalid    (m_axis_tvalid),
    .m_axis_tready    (m_axis_tready),
    .m_axis_tdata     (m_axis_tdata),
    .m_axis_tstrb     (m_axis_tstrb),
    .m_axis_tlast     (m_axis_tlast)
  );

  typedef struct packed {
    logic [DW-1:0] d;
    logic [SW-1:0] s;
    logic          l;
  } beat_t;

  beat_t         exp_q[$];
  beat_t         e_b;
  int            total = 0;
  int            bad = 0;
  int            run_l = 0;
  int            exp_total = 0;
  int            acc_cnt = 0;
  int            out_cnt = 0;
  int            stat_m = 0;
  int            done_cnt = 0;
  int            cyc = 0;
  int            first_acc = -1;
  int            first_out = -1;
  logic [31:0]   last_mask = '0;
  int            vld_pct = 0;
  int            rdy_pct = 0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_d;
  logic [SW-1:0] prev_s;
  logic          prev_l;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // input and output handshake randomization, single owner of the stream-side drives
  always @(posedge clk) begin
    #1;
    s_axis_tvalid = ($urandom_range(99) < vld_pct);
    s_axis_tdata  = {$urandom, $urandom};
    s_axis_tstrb  = SW'($urandom);
    m_axis_tready = ($urandom_range(99) < rdy_pct);
  end

  // reference model: accepted beats queue up in order, tlast every run_l-th accept
  always @(negedge clk) begin
    cyc++;
    if (!reset_n) begin
      prev_stall = 1'b0;
    end else begin
      chk("stat_frames_sent", 64'(stat_frames_sent), 64'(stat_m));
      if (m_axis_tvalid) begin
        if (first_out < 0) first_out = cyc;
        if (prev_stall) begin
          chk("stable_tdata", m_axis_tdata, prev_d);
          chk("stable_tstrb", 64'(m_axis_tstrb), 64'(prev_s));
          chk("stable_tlast", 64'(m_axis_tlast), 64'(prev_l));
        end
        if (m_axis_tready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_beat", 64'(1), 64'(0));
          end else begin
            e_b = exp_q.pop_front();
            chk("out_tdata", m_axis_tdata, e_b.d);
            chk("out_tstrb", 64'(m_axis_tstrb), 64'(e_b.s));
            chk("out_tlast", 64'(m_axis_tlast), 64'(e_b.l));
            if (m_axis_tlast) stat_m++;
            if (out_cnt < 32) last_mask[out_cnt] = m_axis_tlast;
            out_cnt++;
          end
        end
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_d     = m_axis_tdata;
      prev_s     = m_axis_tstrb;
      prev_l     = m_axis_tlast;
      if (ctrl_done) begin
        done_cnt++;
        chk("done_after_all_out", 64'(exp_q.size() == 0 && acc_cnt == exp_total), 64'(1));
      end
      if (s_axis_tvalid && s_axis_tready) begin
        chk("accept_allowed", 64'(acc_cnt < exp_total), 64'(1));
        if (first_acc < 0) first_acc = cyc;
        if (run_l > 0) begin
          e_b.d = s_axis_tdata;
          e_b.s = s_axis_tstrb;
          e_b.l = ((acc_cnt + 1) % run_l) == 0;
          exp_q.push_back(e_b);
        end
        acc_cnt++;
      end
    end
  end

  task automatic start_run(input int l, input int f);
    @(posedge clk);
    #1;
    ctrl_frame_length = LW'(l);
    ctrl_frame_count  = LW'(f);
    ctrl_start        = 1'b1;
    @(posedge clk);
    #1;
    ctrl_start = 1'b0;
    run_l      = l;
    exp_total  = l * f;
    acc_cnt    = 0;
    out_cnt    = 0;
    stat_m     = 0;
    done_cnt   = 0;
    last_mask  = '0;
    first_acc  = -1;
    first_out  = -1;
    exp_q.delete();
  endtask

  task automatic finish_run(input string name, input int budget, input int f, input logic [31:0] mask);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    chk({name, "_done_seen"}, 64'(done_cnt != 0), 64'(1));
    repeat (3) @(posedge clk);
    #2;
    chk({name, "_done_once"}, 64'(done_cnt), 64'(1));
    chk({name, "_busy_clear"}, 64'(ctrl_busy), 64'(0));
    chk({name, "_beats_out"}, 64'(out_cnt), 64'(exp_total));
    chk({name, "_stat"}, 64'(stat_frames_sent), 64'(f));
    chk({name, "_tlast_mask"}, 64'(last_mask), 64'(mask));
    if (exp_total > 0) chk({name, "_latency"}, 64'(first_out - first_acc), 64'(1));
  endtask

  initial begin
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_tvalid", 64'(m_axis_tvalid), 64'(0));
    chk("rst_tready", 64'(s_axis_tready), 64'(0));
    chk("rst_busy", 64'(ctrl_busy), 64'(0));
    chk("rst_done", 64'(ctrl_done), 64'(0));
    chk("rst_stat", 64'(stat_frames_sent), 64'(0));
    chk("rst_tdata", m_axis_tdata, 64'(0));
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // L=4 F=2, streaming at full rate
    vld_pct = 100;
    rdy_pct = 100;
    start_run(4, 2);
    finish_run("t1", 200, 2, 32'h88);

    // L=3 F=1 with downstream stalled
    rdy_pct = 0;
    start_run(3, 1);
    repeat (6) @(negedge clk);
    chk("t2_two_accepted", 64'(acc_cnt), 64'(2));
    chk("t2_tready_low", 64'(s_axis_tready), 64'(0));
    prev_d = m_axis_tdata;
    begin
      logic [DW-1:0] hold;
      hold = m_axis_tdata;
      repeat (3) @(negedge clk);
      chk("t2_tdata_held", m_axis_tdata, hold);
    end
    rdy_pct = 100;
    finish_run("t2", 200, 1, 32'h4);

    // zero length: immediate done, nothing accepted
    start_run(0, 5);
    chk("t3_done_next_cycle", 64'(ctrl_done), 64'(1));
    chk("t3_no_tready", 64'(s_axis_tready), 64'(0));
    finish_run("t3", 20, 0, 32'h0);

    // single-beat frames, with a start pulse injected mid-run
    vld_pct = 70;
    start_run(1, 3);
    chk("t4_busy", 64'(ctrl_busy), 64'(1));
    @(posedge clk);
    #1;
    ctrl_frame_length = LW'(7);
    ctrl_frame_count  = LW'(7);
    ctrl_start        = 1'b1;
    @(posedge clk);
    #1;
    ctrl_start = 1'b0;
    finish_run("t4", 300, 3, 32'h7);

    // random valid/ready, L=5 F=4
    vld_pct = 60;
    rdy_pct = 50;
    start_run(5, 4);
    finish_run("t5", 3000, 4, 32'h84210);

    // reset while two beats sit in the skid
    vld_pct = 100;
    rdy_pct = 0;
    start_run(8, 2);
    begin
      int n = 0;
      while (acc_cnt < 2 && n < 50) begin
        @(negedge clk);
        n++;
      end
      chk("t6_two_in_skid", 64'(acc_cnt), 64'(2));
    end
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_tvalid", 64'(m_axis_tvalid), 64'(0));
    chk("t6_tdata", m_axis_tdata, 64'(0));
    chk("t6_tstrb", 64'(m_axis_tstrb), 64'(0));
    chk("t6_tlast", 64'(m_axis_tlast), 64'(0));
    chk("t6_tready", 64'(s_axis_tready), 64'(0));
    chk("t6_busy", 64'(ctrl_busy), 64'(0));
    chk("t6_done", 64'(ctrl_done), 64'(0));
    exp_q.delete();
    exp_total = 0;
    done_cnt  = 0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (4) @(posedge clk);
    #2;
    chk("t6_no_done", 64'(done_cnt), 64'(0));
    rdy_pct = 100;
    start_run(2, 1);
    finish_run("t6", 200, 1, 32'h2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
